// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Shared op-code and state encodings for the universal shift
//                register and its one-step datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    // Command op codes as seen on cmd_op
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_SHR   = 3'd2,
        OP_SHL   = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_ASR   = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    // Burst engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_reg_univ_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_univ_step
//  Description : Combinational single-step next value for the shift/rotate
//                op codes. Non-shift op codes pass the data through.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_univ_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_serial_in_msb,
    input  logic             i_serial_in_lsb,
    output logic [WIDTH-1:0] o_data_next
);

    // One shift of the requested kind; anything else holds the value
    always_comb begin
        o_data_next = i_data;
        case (i_op)
            OP_SHR:  o_data_next = {i_serial_in_msb, i_data[WIDTH-1:1]};
            OP_SHL:  o_data_next = {i_data[WIDTH-2:0], i_serial_in_lsb};
            OP_ROR:  o_data_next = {i_data[0], i_data[WIDTH-1:1]};
            OP_ROL:  o_data_next = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
            OP_ASR:  o_data_next = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
            default: o_data_next = i_data;
        endcase
    end

endmodule : shift_reg_univ_step
`default_nettype wire

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_univ
//  Description : Universal shift register with a command-driven burst engine.
//                LOAD/CLEAR/NOP complete immediately; shift/rotate ops run
//                for cmd_count cycles, then a one-cycle done pulse follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in_msb,
    input  logic             serial_in_lsb,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out_lsb,
    output logic             serial_out_msb,
    output logic             busy,
    output logic             done
);

    state_e             r_state;
    op_e                r_op;
    logic [WIDTH-1:0]   r_data;
    logic [CNT_W-1:0]   r_remaining;

    state_e             w_state_nxt;
    op_e                w_op_nxt;
    op_e                w_cmd_op;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [WIDTH-1:0]   w_step_data;
    logic [CNT_W-1:0]   w_remaining_nxt;

    assign w_cmd_op = op_e'(cmd_op);

    // Only the latched op is ever stepped; immediate ops never reach RUN
    shift_reg_univ_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op            (r_op),
        .i_data          (r_data),
        .i_serial_in_msb (serial_in_msb),
        .i_serial_in_lsb (serial_in_lsb),
        .o_data_next     (w_step_data)
    );

    // Next-state, next-data and remaining-count decisions
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_data_nxt      = r_data;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (w_cmd_op)
                        OP_NOP:   w_state_nxt = ST_DONE;
                        OP_LOAD: begin
                            w_data_nxt  = load_data;
                            w_state_nxt = ST_DONE;
                        end
                        OP_CLEAR: begin
                            w_data_nxt  = '0;
                            w_state_nxt = ST_DONE;
                        end
                        default: begin
                            // Zero-length burst completes like an immediate op
                            if (cmd_count == '0) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_op_nxt        = w_cmd_op;
                                w_remaining_nxt = cmd_count;
                                w_state_nxt     = ST_RUN;
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                w_data_nxt      = w_step_data;
                w_remaining_nxt = r_remaining - CNT_W'(1);
                if (r_remaining == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, op latch, counter and data register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_data      <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_data      <= w_data_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    assign cmd_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state == ST_RUN);
    assign done           = (r_state == ST_DONE);
    assign data_out       = r_data;
    assign serial_out_lsb = r_data[0];
    assign serial_out_msb = r_data[WIDTH-1];

endmodule : shift_reg_univ
`default_nettype wire

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register with a command-driven burst engine. It is the successor to the fixed 4-bit right-shift register. Supports parallel load, clear, logical left/right shift, rotate and arithmetic right shift, each applied for a programmed number of cycles. It sits between control logic issuing commands and serial/parallel datapaths consuming the register contents.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 4, width of shift-count field; counts 0..2^CNT_W-1

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high when the block can accept a command
cmd_op  input  3  operation code (encodings below)
cmd_count  input  CNT_W  number of shift cycles for shift/rotate ops
load_data  input  WIDTH  parallel load value, sampled on acceptance of LOAD
serial_in_msb  input  1  bit entering MSB on SHR
serial_in_lsb  input  1  bit entering LSB on SHL
data_out  output  WIDTH  current register contents
serial_out_lsb  output  1  data_out[0]
serial_out_msb  output  1  data_out[WIDTH-1]
busy  output  1  high while shift cycles are executing
done  output  1  one-cycle pulse on command completion

Behaviour:
- Interface is decided: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset (sampled high at a rising edge): data register = 0, state = IDLE, count = 0, done = 0. busy = 0 and cmd_ready = 1 after that edge. Reset overrides every other input.
- Op codes:
  - 0 NOP
  - 1 LOAD
  - 2 SHR: {serial_in_msb, d[W-1:1]}
  - 3 SHL: {d[W-2:0], serial_in_lsb}
  - 4 ROR
  - 5 ROL
  - 6 ASR: {d[W-1], d[W-1:1]}
  - 7 CLEAR
- Handshake:
  - A command is accepted at a rising edge where cmd_valid && cmd_ready.
  - cmd_ready = (state == IDLE), driven combinationally from state.
  - cmd_valid while not ready is ignored; no queuing.
- States: IDLE, RUN, DONE.
- Transitions from IDLE on acceptance:
  - LOAD: register <= load_data at the accept edge. Next state DONE.
  - CLEAR: register <= 0 at the accept edge. Next state DONE.
  - NOP: register unchanged. Next state DONE.
  - Shift ops (2..6) with cmd_count == 0: register unchanged. Next state DONE.
  - Shift ops with cmd_count = K > 0: latch op, remaining <= K. Next state RUN.
- RUN:
  - Each edge applies one shift of the latched op; remaining decrements.
  - Serial inputs are sampled at each RUN edge, so they may change per cycle.
  - The edge where remaining == 1 applies the last shift and moves to DONE.
  - K shifts take exactly K RUN cycles. K > WIDTH is legal; rotates wrap (net rotate = K mod WIDTH) and logical shifts fully flush.
- DONE: done = 1 for exactly one cycle, cmd_ready = 0. Next state IDLE.
- Latency:
  - Shift by K accepted at edge t0: last shift lands at edge t0+K; done is high during cycle t0+K to t0+K+1; next command can be accepted at edge t0+K+2.
  - LOAD/CLEAR/NOP/K=0: done is high during cycle t0 to t0+1; next accept at edge t0+2.
- busy = (state == RUN). done = (state == DONE). Both are registered-state decodes.
- Reset mid-RUN: shift abandoned, register cleared, no done pulse.
- Command inputs are don't-care except at the accept edge. load_data is used only for LOAD.

Decomposition:
- Package shift_reg_pkg:
  - op-code localparams / enum (OP_NOP..OP_CLEAR, 3 bits)
  - state enum (ST_IDLE, ST_RUN, ST_DONE)
- Sub-module shift_reg_univ_step: purely combinational one-step next-value function (op, data, serial_in_msb, serial_in_lsb -> next data). The top holds the FSM, counter and register, and instantiates one step unit.

Test Plan:
1. Hold reset 2 cycles with cmd_valid=1, cmd_op=LOAD, load_data=0xF -> data_out=0x0, cmd_ready=1, busy=0, done=0 after reset; LOAD not applied.
2. LOAD 0xA, then SHR K=1 with serial_in_msb=1 -> data_out=0xD one edge after accept, done pulse the following cycle, serial_out_lsb=1.
3. LOAD 0x9, ROL K=5 -> data_out=0x3 after 5 RUN cycles; busy high exactly 5 cycles; single done pulse.
4. LOAD 0x8, ASR K=2 -> 0xC then 0xE; then SHL K=0 -> data_out stays 0xE, done pulses the cycle after accept.
5. SHL K=6 from 0xF with serial_in_lsb=0 -> 0x0. A second cmd_valid during RUN is ignored: cmd_ready=0 and data unchanged by it.
6. LOAD 0x5, SHR K=7, assert reset at 3rd RUN cycle -> data_out=0x0, state IDLE, no done pulse; a new LOAD 0x6 is accepted the next cycle.
